// File: rtl/dht11_pkg.sv
// dht11_pkg: shared state encoding and default DHT11 timing constants (100 MHz clock cycles).
package dht11_pkg;
  typedef enum logic [3:0] {IDLE, START, RESP, ACK_L, ACK_H, BIT_L, BIT_H, END_L, GUARD} state_t;
  localparam int START_MIN  = 1_800_000;
  localparam int RESP_WAIT  = 3_000;
  localparam int ACK_LOW    = 8_000;
  localparam int ACK_HIGH   = 8_000;
  localparam int BIT_LOW    = 5_000;
  localparam int BIT0_HIGH  = 2_700;
  localparam int BIT1_HIGH  = 7_000;
  localparam int FRAME_BITS = 40;
endpackage

// File: rtl/dht11_frame_builder.sv
// dht11_frame_builder: packs the four data bytes plus an optionally corrupted 8-bit checksum.
module dht11_frame_builder import dht11_pkg::*; (
  input  logic [7:0]            hum_int,
  input  logic [7:0]            hum_dec,
  input  logic [7:0]            tmp_int,
  input  logic [7:0]            tmp_dec,
  input  logic                  corrupt_chk,
  output logic [FRAME_BITS-1:0] frame
);
  logic [7:0] sum;
  assign sum   = hum_int + hum_dec + tmp_int + tmp_dec;
  assign frame = {hum_int, hum_dec, tmp_int, tmp_dec, sum ^ {7'b0, corrupt_chk}};
endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: sensor-side DHT11 emulator; detects the host start pulse, acknowledges,
// then sends a 40-bit frame MSB first on an open-drain line.
module dht11_responder #(
  parameter int START_MIN = dht11_pkg::START_MIN,
  parameter int RESP_WAIT = dht11_pkg::RESP_WAIT,
  parameter int ACK_LOW   = dht11_pkg::ACK_LOW,
  parameter int ACK_HIGH  = dht11_pkg::ACK_HIGH,
  parameter int BIT_LOW   = dht11_pkg::BIT_LOW,
  parameter int BIT0_HIGH = dht11_pkg::BIT0_HIGH,
  parameter int BIT1_HIGH = dht11_pkg::BIT1_HIGH,
  parameter int CNT_W     = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  inout  wire        data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       corrupt_chk,
  output logic       busy,
  output logic       frame_done
);
  import dht11_pkg::*;
  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n, phase_len;
  logic [FRAME_BITS-1:0] shift, shift_n, frame;
  logic [5:0]            idx, idx_n;
  logic                  drive_low, drive_n, busy_n, done_n, rx_meta, rx, last, long_start;
  dht11_frame_builder u_frame (
    .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
    .corrupt_chk(corrupt_chk), .frame(frame)
  );
  assign data       = drive_low ? 1'b0 : 1'bz;
  assign phase_len  = state == RESP  ? CNT_W'(RESP_WAIT) :
                      state == ACK_L ? CNT_W'(ACK_LOW) :
                      state == ACK_H ? CNT_W'(ACK_HIGH) :
                      state == BIT_H ? (shift[FRAME_BITS-1] ? CNT_W'(BIT1_HIGH) : CNT_W'(BIT0_HIGH)) :
                      CNT_W'(BIT_LOW);
  assign last       = cnt == phase_len - 1'b1;
  assign long_start = cnt >= CNT_W'(START_MIN);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      {rx_meta, rx} <= 2'b11;
      state         <= IDLE;
      cnt           <= '0;
      shift         <= '0;
      idx           <= '0;
      drive_low     <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      {rx_meta, rx} <= {data, rx_meta};
      state         <= state_n;
      cnt           <= cnt_n;
      shift         <= shift_n;
      idx           <= idx_n;
      drive_low     <= drive_n;
      busy          <= busy_n;
      frame_done    <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    shift_n = shift;
    idx_n   = idx;
    drive_n = drive_low;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx) state_n = START;
      end
      START:
        if (rx) begin
          cnt_n   = '0;
          state_n = long_start ? RESP : IDLE;
          busy_n  = long_start;
          shift_n = long_start ? frame : shift;
        end else if (long_start) cnt_n = cnt;
      RESP:  if (last) {state_n, drive_n, cnt_n} = {ACK_L, 1'b1, CNT_W'(0)};
      ACK_L: if (last) {state_n, drive_n, cnt_n} = {ACK_H, 1'b0, CNT_W'(0)};
      ACK_H: if (last) {state_n, drive_n, cnt_n, idx_n} = {BIT_L, 1'b1, CNT_W'(0), 6'd0};
      BIT_L: if (last) {state_n, drive_n, cnt_n} = {BIT_H, 1'b0, CNT_W'(0)};
      BIT_H:
        if (last) begin
          state_n = idx == 6'(FRAME_BITS - 1) ? END_L : BIT_L;
          shift_n = shift << 1;
          idx_n   = idx + 1'b1;
          drive_n = 1'b1;
          cnt_n   = '0;
        end
      END_L: if (last) {state_n, drive_n, cnt_n, done_n, busy_n} = {GUARD, 1'b0, CNT_W'(0), 1'b1, 1'b0};
      GUARD: begin
        cnt_n = '0;
        if (rx) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: table-driven frame checks plus hand-written start/reset corner sequences.
module tb_dht11_responder;
  localparam int SM = 20, RW = 6, AL = 10, AH = 9, BL = 5, B0 = 3, B1 = 7, LIM = 1000;
  typedef struct {
    logic [7:0] hi, hd, ti, td;
    logic       cor;
    logic [7:0] chk;
  } vec_t;
  logic       clock = 0, reset_n = 0, host_low = 0, corrupt_chk = 0, busy, frame_done;
  logic [7:0] hum_int = 0, hum_dec = 0, tmp_int = 0, tmp_dec = 0;
  wire        data;
  int         cmp = 0, errs = 0, done_cnt = 0;
  vec_t       vecs[5];
  pullup (data);
  assign data = host_low ? 1'b0 : 1'bz;
  always #5 clock = ~clock;
  always @(posedge clock) begin
    #2;
    if (frame_done) done_cnt++;
  end
  dht11_responder #(
    .START_MIN(SM), .RESP_WAIT(RW), .ACK_LOW(AL), .ACK_HIGH(AH),
    .BIT_LOW(BL), .BIT0_HIGH(B0), .BIT1_HIGH(B1), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .hum_int(hum_int), .hum_dec(hum_dec),
    .tmp_int(tmp_int), .tmp_dec(tmp_dec), .corrupt_chk(corrupt_chk), .busy(busy),
    .frame_done(frame_done)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    cmp++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // counts negedge samples for which the bus stays at level v
  task automatic measure(input logic v, output int n);
    n = 0;
    while (data === v && n < LIM) begin
      n++;
      @(negedge clock);
    end
    if (n >= LIM) begin
      cmp++;
      errs++;
      $display("FAIL timeout: bus stuck at %0d for %0d cycles, expected a transition", v, n);
    end
  endtask

  task automatic host_start(input int len);
    host_low = 1;
    repeat (len) @(negedge clock);
    host_low = 0;
    @(negedge clock);
  endtask

  task automatic run_frame(input logic [7:0] hi, hd, ti, td, input logic cor, input logic [7:0] chk,
                           input int chg_bit, input logic [7:0] chg_val);
    logic [39:0] exp, got;
    logic [7:0]  s;
    int          n, d0;
    exp = {hi, hd, ti, td, chk};
    got = '0;
    {hum_int, hum_dec, tmp_int, tmp_dec, corrupt_chk} = {hi, hd, ti, td, cor};
    d0 = done_cnt;
    host_start(2 * SM);
    // two extra cycles come from the bus synchronizer
    measure(1'b1, n); check("resp_wait", n, RW + 2);
    check("busy_in_frame", busy, 1);
    measure(1'b0, n); check("ack_low", n, AL);
    measure(1'b1, n); check("ack_high", n, AH);
    for (int i = 0; i < 40; i++) begin
      if (i == chg_bit) hum_int = chg_val;
      measure(1'b0, n); check($sformatf("bit%0d_low", i), n, BL);
      measure(1'b1, n); check($sformatf("bit%0d_high", i), n, exp[39-i] ? B1 : B0);
      got = {got[38:0], n > BL};
    end
    measure(1'b0, n); check("end_low", n, BL);
    check("busy_after", busy, 0);
    check("done_pulse", done_cnt - d0, 1);
    check("frame", got, exp);
    s = got[39:32] + got[31:24] + got[23:16] + got[15:8];
    check("chk_valid", s == got[7:0], !cor);
    repeat (10) @(negedge clock);
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int  n, d0;
    logic saw_busy, saw_low;
    vecs[0] = '{8'h37, 8'h00, 8'h18, 8'h05, 1'b0, 8'h54};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 8'hFE};
    vecs[2] = '{8'h10, 8'h00, 8'h20, 8'h00, 1'b1, 8'h31};
    vecs[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 8'h0A};
    vecs[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 8'h00};
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_bus", data, 1);
    reset_n = 1;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].hi, vecs[i].hd, vecs[i].ti, vecs[i].td, vecs[i].cor, vecs[i].chk, -1, 8'h00);
    // short host pulse must be ignored
    d0 = done_cnt;
    saw_busy = 0;
    saw_low = 0;
    host_start(SM / 2);
    repeat (100) begin
      saw_busy |= busy;
      saw_low |= (data === 1'b0);
      @(negedge clock);
    end
    check("short_busy", saw_busy, 0);
    check("short_drive", saw_low, 0);
    check("short_done", done_cnt - d0, 0);
    // input change mid-frame does not reach the frame in flight
    run_frame(8'h37, 8'h00, 8'h18, 8'h05, 1'b0, 8'h54, 5, 8'h99);
    run_frame(8'h99, 8'h00, 8'h18, 8'h05, 1'b0, 8'hB6, -1, 8'h00);
    // async reset during the acknowledge low
    hum_int = 8'h37;
    host_start(2 * SM);
    measure(1'b1, n);
    repeat (3) @(negedge clock);
    check("ackl_driving", data, 0);
    reset_n = 0;
    #1;
    check("rst_mid_bus", data, 1);
    check("rst_mid_busy", busy, 0);
    @(negedge clock);
    reset_n = 1;
    repeat (5) @(negedge clock);
    run_frame(8'h37, 8'h00, 8'h18, 8'h05, 1'b0, 8'h54, -1, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Emulates the sensor end of the DHT11 single-wire protocol.
- Detects the host start pulse, answers with the 80 us low / 80 us high acknowledge, then transmits a 40-bit frame: humidity int, humidity dec, temp int, temp dec, checksum.
- Used as a sensor model in bench and loopback builds, and drives the same `data` net the sensor driver reads.
- Clock is 100 MHz; all timings are in clock cycles.

Parameters:
- START_MIN, 1_800_000, minimum host low time accepted as a start (18 ms).
- RESP_WAIT, 3_000, delay from host release to acknowledge low (30 us).
- ACK_LOW, 8_000, acknowledge low time (80 us).
- ACK_HIGH, 8_000, acknowledge high time (80 us).
- BIT_LOW, 5_000, low preamble of every bit and of the end marker (50 us).
- BIT0_HIGH, 2_700, high time encoding 0 (27 us).
- BIT1_HIGH, 7_000, high time encoding 1 (70 us).
- CNT_W, 21, timing counter width; must hold START_MIN.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- data  inout  1  open-drain bus; driven 0 or Z only, never 1; external pull-up.
- hum_int  in  8  humidity integer byte.
- hum_dec  in  8  humidity decimal byte.
- tmp_int  in  8  temperature integer byte.
- tmp_dec  in  8  temperature decimal byte.
- corrupt_chk  in  1  when 1, transmitted checksum has bit0 inverted.
- busy  out  1  high from accepted start until frame end.
- frame_done  out  1  one-cycle pulse when the end marker is released.

Behaviour:
- Bus:
  - `data = drive_low ? 0 : Z`; drive_low is a register.
  - The line is read through a 2-FF synchronizer, rx. Z/pull-up reads as 1.
- Reset (async, reset_n=0):
  - state=IDLE, drive_low=0 (bus released immediately, including mid-frame), busy=0, frame_done=0.
  - Counter, shift register and bit index cleared.
- States and transitions:
  - IDLE: when rx==0 → START, counter=0.
  - START: counter increments while rx==0, saturating at START_MIN.
    - On rx==1: if counter>=START_MIN → RESP, counter=0, busy=1, latch frame. Otherwise → IDLE with no response.
  - RESP: on counter==RESP_WAIT-1 → ACK_L, drive_low=1, counter=0.
  - ACK_L: after ACK_LOW cycles → ACK_H, drive_low=0.
  - ACK_H: after ACK_HIGH cycles → BIT_L, drive_low=1, bit index=0.
  - BIT_L: after BIT_LOW cycles → BIT_H, drive_low=0.
  - BIT_H: after BIT0_HIGH or BIT1_HIGH cycles, chosen by the current MSB of the shift register:
    - Shift left and increment index.
    - If index was 39 → END_L. Otherwise → BIT_L. In both cases drive_low=1.
  - END_L: after BIT_LOW cycles → GUARD, drive_low=0, frame_done=1 for one cycle, busy=0.
  - GUARD: wait for rx==1, which suppresses the synchronizer echo of its own low, then → IDLE.
- Frame latch (at the START→RESP transition):
  - shift[39:0] = {hum_int, hum_dec, tmp_int, tmp_dec, chk}, sent MSB first.
  - chk = (hum_int+hum_dec+tmp_int+tmp_dec) mod 256, computed as an 8-bit truncated sum, XOR {7'b0, corrupt_chk}.
  - Input changes after the latch do not affect the frame in flight.
- rx is ignored in RESP through END_L; host activity during a frame does not abort it.
- Phase length: each timed phase lasts exactly its parameter value in cycles, measured from the drive_low edge.
- Total frame, from host release to final release: RESP_WAIT + ACK_LOW + ACK_HIGH + 40·BIT_LOW + Σhigh + BIT_LOW.

Decomposition:
- Shared package `dht11_pkg`:
  - state enumeration.
  - Default timing constants: START_MIN, RESP_WAIT, ACK_LOW, ACK_HIGH, BIT_LOW, BIT0_HIGH, BIT1_HIGH. Shared with the sensor driver.
  - FRAME_BITS=40.
- One natural sub-module: `dht11_frame_builder`. It is combinational: it packs the four bytes, adds the checksum and applies corrupt_chk, producing the 40-bit word.
- Synchronizer is inline.

Test Plan:
- Host pulls data low for 2_000_000 cycles then releases; bytes 0x37,0x00,0x18,0x05 → data falls 3_000 cycles after release; low 8_000, high 8_000; then 40 bits with checksum 0x54; frame_done pulses once; busy returns to 0.
- Bit timing check on bytes 0xFF,0x00,0xFF,0x00 → every bit low exactly 5_000; high 7_000 for 1s and 2_700 for 0s; checksum 0xFE.
- Host low for 1_000_000 cycles (short) → no drive on data, busy stays 0, state returns to IDLE.
- corrupt_chk=1 with bytes 0x10,0x00,0x20,0x00 → checksum transmitted 0x31; a sensor-driver instance on the bus keeps data_ready=0.
- Change hum_int from 0x37 to 0x99 during bit 5 → the frame still carries 0x37; the next start carries 0x99.
- Assert reset_n=0 during ACK_L → data released to Z in the same cycle, busy=0; after reset deassert a new valid start is answered normally.
